// File: rtl/ram_128x32.sv
// 128-byte big-endian data memory with a 32-bit port for the SPARC V8 datapath.
// A request in IDLE is serviced at that edge and acknowledged by a one-cycle MFC pulse.
module ram_128x32 (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] DataOut,
    output logic        MFC,
    input  logic        Enable,
    input  logic [5:0]  OpCode,
    input  logic [6:0]  Address,
    input  logic [31:0] DataIn
);

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_mfc;
    logic [31:0] r_dout;
    logic [7:0]  r_mem [128];

    logic [6:0]  w_idx   [4];
    logic [7:0]  w_rbyte [4];
    logic [7:0]  w_wbyte [4];
    logic [3:0]  w_we;
    logic        w_ld_valid;
    logic [31:0] w_ld_data;

    // Byte lanes: lane k addresses Mem[Address+k]; the 7-bit sum wraps around the array.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_idx[k]   = Address + 7'(k);
            w_rbyte[k] = r_mem[w_idx[k]];
        end
    end

    // Load decode: align the addressed bytes into the low end and extend.
    always_comb begin
        w_ld_valid = 1'b0;
        w_ld_data  = 32'h0000_0000;
        case (OpCode)
            OP_LD: begin
                w_ld_valid = 1'b1;
                w_ld_data  = {w_rbyte[0], w_rbyte[1], w_rbyte[2], w_rbyte[3]};
            end
            OP_LDUB: begin
                w_ld_valid = 1'b1;
                w_ld_data  = {24'h00_0000, w_rbyte[0]};
            end
            OP_LDUH: begin
                w_ld_valid = 1'b1;
                w_ld_data  = {16'h0000, w_rbyte[0], w_rbyte[1]};
            end
            OP_LDSB: begin
                w_ld_valid = 1'b1;
                w_ld_data  = {{24{w_rbyte[0][7]}}, w_rbyte[0]};
            end
            OP_LDSH: begin
                w_ld_valid = 1'b1;
                w_ld_data  = {{16{w_rbyte[0][7]}}, w_rbyte[0], w_rbyte[1]};
            end
            default: begin
                w_ld_valid = 1'b0;
                w_ld_data  = 32'h0000_0000;
            end
        endcase
    end

    // Store decode: the most significant stored byte goes to the lowest address.
    always_comb begin
        w_we = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_wbyte[k] = 8'h00;
        end
        case (OpCode)
            OP_ST: begin
                w_we       = 4'b1111;
                w_wbyte[0] = DataIn[31:24];
                w_wbyte[1] = DataIn[23:16];
                w_wbyte[2] = DataIn[15:8];
                w_wbyte[3] = DataIn[7:0];
            end
            OP_STH: begin
                w_we       = 4'b0011;
                w_wbyte[0] = DataIn[15:8];
                w_wbyte[1] = DataIn[7:0];
            end
            OP_STB: begin
                w_we       = 4'b0001;
                w_wbyte[0] = DataIn[7:0];
            end
            default: begin
                w_we = 4'b0000;
            end
        endcase
    end

    // Access sequencer, storage and registered outputs; reset wins over any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mfc   <= 1'b0;
            r_dout  <= 32'h0000_0000;
            for (int i = 0; i < 128; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Enable) begin
                        r_state <= ST_DONE;
                        r_mfc   <= 1'b1;
                        if (w_ld_valid) begin
                            r_dout <= w_ld_data;
                        end
                        for (int k = 0; k < 4; k++) begin
                            if (w_we[k]) begin
                                r_mem[w_idx[k]] <= w_wbyte[k];
                            end
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_mfc   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_mfc   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_mfc   <= 1'b0;
                end
            endcase
        end
    end

    assign DataOut = r_dout;
    assign MFC     = r_mfc;

endmodule

// File: tb/tb_ram_128x32.sv
// Directed self-checking bench for ram_128x32: expected DataOut values are queued
// when each access is issued and compared when its MFC pulse appears.
module tb_ram_128x32;

    logic        clk;
    logic        reset;
    logic [31:0] DataOut;
    logic        MFC;
    logic        Enable;
    logic [5:0]  OpCode;
    logic [6:0]  Address;
    logic [31:0] DataIn;

    int          vectors;
    int          fails;
    int          pulses;
    logic [31:0] held;
    logic [31:0] sb [$];

    ram_128x32 dut (
        .clk     (clk),
        .reset   (reset),
        .DataOut (DataOut),
        .MFC     (MFC),
        .Enable  (Enable),
        .OpCode  (OpCode),
        .Address (Address),
        .DataIn  (DataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One access: queue the expected DataOut, issue, wait (bounded) for MFC, compare.
    task automatic access(input string tag, input logic [5:0] op, input logic [6:0] addr,
                          input logic [31:0] din, input logic [31:0] exp);
        int n;
        logic [31:0] e;
        sb.push_back(exp);
        @(negedge clk);
        Enable = 1'b1; OpCode = op; Address = addr; DataIn = din;
        @(negedge clk);
        Enable = 1'b0;
        n = 0;
        while (MFC !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_mfc"}, MFC, 1'b1);
        e = sb.pop_front();
        chk32({tag, "_data"}, DataOut, e);
        @(negedge clk);
        chk1({tag, "_mfc_low"}, MFC, 1'b0);
    endtask

    task automatic load(input string tag, input logic [5:0] op, input logic [6:0] addr,
                        input logic [31:0] exp);
        access(tag, op, addr, 32'h0000_0000, exp);
        held = exp;
    endtask

    task automatic store(input string tag, input logic [5:0] op, input logic [6:0] addr,
                         input logic [31:0] din);
        access(tag, op, addr, din, held);
    endtask

    initial begin
        vectors = 0; fails = 0; held = 32'h0000_0000;
        reset = 1'b1; Enable = 1'b0; OpCode = 6'b000000; Address = 7'd0; DataIn = 32'h0000_0000;
        repeat (3) @(negedge clk);
        chk32("reset_dout", DataOut, 32'h0000_0000);
        chk1("reset_mfc", MFC, 1'b0);
        reset = 1'b0;

        load("ld0",   6'b000000, 7'd0,   32'h0000_0000);
        load("ld4",   6'b000000, 7'd4,   32'h0000_0000);
        load("ld124", 6'b000000, 7'd124, 32'h0000_0000);

        store("st0", 6'b000100, 7'd0, 32'hFFFF_FFE8);
        load("ld0_neg24", 6'b000000, 7'd0, 32'hFFFF_FFE8);
        load("ldub3",     6'b000001, 7'd3, 32'h0000_00E8);
        load("ldsb3",     6'b001001, 7'd3, 32'hFFFF_FFE8);
        load("lduh2",     6'b000010, 7'd2, 32'h0000_FFE8);
        load("ldub0",     6'b000001, 7'd0, 32'h0000_00FF);

        store("stb5", 6'b000101, 7'd5, 32'hDEAD_BEAB);
        store("sth6", 6'b000110, 7'd6, 32'hCAFE_1234);
        load("ld4_mix",  6'b000000, 7'd4, 32'h00AB_1234);
        load("ldsh6",    6'b001010, 7'd6, 32'h0000_1234);
        load("ldsb5",    6'b001001, 7'd5, 32'hFFFF_FFAB);
        load("lduh5",    6'b000010, 7'd5, 32'h0000_AB12);
        load("ld2_unal", 6'b000000, 7'd2, 32'hFFE8_00AB);

        store("st126", 6'b000100, 7'd126, 32'h1122_3344);
        load("ldub0_wrap",   6'b000001, 7'd0,   32'h0000_0033);
        load("ldub127_wrap", 6'b000001, 7'd127, 32'h0000_0022);
        load("ld126_wrap",   6'b000000, 7'd126, 32'h1122_3344);
        load("ldsh127_wrap", 6'b001010, 7'd127, 32'h0000_2233);
        store("sth127", 6'b000110, 7'd127, 32'h0000_8899);
        load("ldsh127_neg",  6'b001010, 7'd127, 32'hFFFF_8899);
        load("ld126_after",  6'b000000, 7'd126, 32'h1188_9944);

        store("bad_op3f", 6'b111111, 7'd126, 32'hFFFF_FFFF);
        load("ld126_keep", 6'b000000, 7'd126, 32'h1188_9944);
        store("bad_op07", 6'b000111, 7'd0, 32'h0000_0000);
        load("ld0_keep",   6'b000000, 7'd0, 32'h9944_FFE8);

        // Enable held for 10 cycles: MFC must alternate 1,0,... for 5 pulses.
        pulses = 0;
        @(negedge clk);
        Enable = 1'b1; OpCode = 6'b000000; Address = 7'd4; DataIn = 32'h0000_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (MFC === 1'b1) pulses++;
            chk1("burst_mfc", MFC, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        Enable = 1'b0;
        vectors++;
        assert (pulses == 5) else begin
            fails++;
            $error("FAIL burst_pulses: observed %0d expected 5", pulses);
        end
        chk32("burst_data", DataOut, 32'h00AB_1234);

        // Reset during the MFC cycle.
        @(negedge clk);
        Enable = 1'b1; OpCode = 6'b000000; Address = 7'd0;
        @(negedge clk);
        Enable = 1'b0;
        chk1("pre_rst_mfc", MFC, 1'b1);
        chk32("pre_rst_data", DataOut, 32'h9944_FFE8);
        reset = 1'b1;
        @(negedge clk);
        chk1("rst_in_done_mfc", MFC, 1'b0);
        chk32("rst_in_done_dout", DataOut, 32'h0000_0000);
        reset = 1'b0;
        held = 32'h0000_0000;
        load("ld0_cleared",   6'b000000, 7'd0,   32'h0000_0000);
        load("ld4_cleared",   6'b000000, 7'd4,   32'h0000_0000);
        load("ld126_cleared", 6'b000000, 7'd126, 32'h0000_0000);

        // Reset together with Enable discards the store.
        @(negedge clk);
        Enable = 1'b1; OpCode = 6'b000100; Address = 7'd8; DataIn = 32'h5A5A_5A5A; reset = 1'b1;
        @(negedge clk);
        Enable = 1'b0; reset = 1'b0;
        chk1("rst_en_mfc", MFC, 1'b0);
        load("ld8_discarded", 6'b000000, 7'd8, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
